ltl_monitor_cluster: RTL and testbench
======================================

LTL_MONITOR_CLUSTER -- requirements
Module: ltl_monitor_cluster

Interface
REQ-001 Parameter NUM_PROPS, default 9, number of monitored LTL properties.
REQ-002 Parameter NUM_REPORTS, default 4, report states per property automaton.
REQ-003 Parameter SYMBOL_W, default 8, input symbol width.
REQ-004 Parameter CNT_W, default 16, per-property violation counter width.
REQ-005 Parameter CYC_W, default 32, cycle timestamp width.
REQ-006 Parameter EVT_DEPTH, default 8, event queue depth (power of two, >=2).
REQ-007 One clock; reset is synchronous and active-high.
REQ-008 Port clk, input, 1, the single clock.
REQ-009 Port reset, input, 1, synchronous active-high reset.
REQ-010 Port run, input, 1, symbol-valid/advance qualifier.
REQ-011 Port symbols, input, SYMBOL_W, current symbol.
REQ-012 Port report_states, input, NUM_PROPS*NUM_REPORTS, raw report-state activations, property p in slice [p*NUM_REPORTS +: NUM_REPORTS].
REQ-013 Port prop_enable, input, NUM_PROPS, per-property enable mask.
REQ-014 Port clear, input, 1, clears sticky flags, counters and overflow.
REQ-015 Port ltl, output, NUM_PROPS, registered per-property fire.
REQ-016 Port ltl_sticky, output, NUM_PROPS, latched fire flags.
REQ-017 Port viol_count, output, NUM_PROPS*CNT_W, saturating fire counts.
REQ-018 Port evt_valid/evt_ready, output/input, 1 each, event-queue handshake.
REQ-019 Port evt_mask, evt_cycle, evt_symbol, outputs, NUM_PROPS, CYC_W and SYMBOL_W, head event payload.
REQ-020 Port evt_overflow, output, 1, sticky event-drop flag.

Function
REQ-021 fire[p] = run & prop_enable[p] & OR of property p's report slice.
REQ-022 ltl[p] shall equal fire[p] delayed by exactly one clk.
REQ-023 ltl_sticky[p] shall set the cycle after fire[p]; clear resets it, but fire[p] in the same cycle wins (stays 1).
REQ-024 viol_count[p] shall increment by 1 per fire[p] cycle, saturate at 2^CNT_W-1, never wrap; clear zeroes it, and a same-cycle fire loads 1.
REQ-025 Cycle counter shall increment on every run cycle, wrap modulo 2^CYC_W and hold when run is low; clear does not affect it.
REQ-026 Each cycle with any fire bit set shall push one entry {fire, cycle-counter value before increment, symbols}.
REQ-027 Pop occurs when evt_valid & evt_ready; evt_valid shall be high exactly when the queue is non-empty.
REQ-028 No bypass: a push into an empty queue makes evt_valid high the next cycle.
REQ-029 Push while full without a same-cycle pop shall drop the entry and set evt_overflow; push and pop together while full shall both be accepted.
REQ-030 Payload outputs shall be stable while evt_valid & !evt_ready.
REQ-031 evt_overflow shall clear only on clear or reset; a same-cycle drop wins over clear.
REQ-032 run low shall suppress all fires, but the queue shall keep draining.

Reset
REQ-033 On reset: ltl, ltl_sticky, viol_count, cycle counter, evt_overflow, and queue pointers/occupancy shall all be 0; evt_valid 0.
REQ-034 Reset mid-operation shall discard queued events and override clear, run and all same-cycle fires.

Structure
REQ-035 Shared package ltl_mon_pkg holds default parameter constants and the event-entry struct typedef.
REQ-036 Event queue shall be a sub-module ltl_evt_fifo (synchronous, registered outputs, full/empty flags).

Verification
REQ-037 NUM_PROPS=9, enable all ones, run=1, report bit 2 of prop 3 high for one cycle at cycle-count 5 -> ltl[3]=1 the next cycle only; sticky[3]=1; count[3]=1; one event with mask 0x008, cycle 5, and that cycle's symbol.
REQ-038 CNT_W=4, prop 0 fires for 20 consecutive cycles -> viol_count[0] stops at 15.
REQ-039 EVT_DEPTH=8, evt_ready=0, fires on 10 cycles -> 8 entries queued, evt_overflow=1, first 8 drained in order; then 8 fires with evt_ready=1 held -> all accepted with no new drop.
REQ-040 Props 1 and 4 fire in the same cycle with prop_enable[4]=0 -> mask 0x002; ltl[4], sticky[4] and count[4] unchanged.
REQ-041 clear and a fire of prop 2 in the same cycle -> sticky[2]=1, count[2]=1, all other flags and counts 0.
REQ-042 reset asserted with 3 events queued and run=1 -> next cycle evt_valid=0, all outputs 0, cycle counter 0.

Source files
------------

// File: rtl/ltl_mon_pkg.sv
// ltl_mon_pkg: default cluster parameters and the event-queue entry layout
package ltl_mon_pkg;
  localparam int DEF_NUM_PROPS = 9;
  localparam int DEF_NUM_REPORTS = 4;
  localparam int DEF_SYMBOL_W = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_CYC_W = 32;
  localparam int DEF_EVT_DEPTH = 8;
  typedef struct packed {
    logic [DEF_NUM_PROPS-1:0] mask;
    logic [DEF_CYC_W-1:0] cycle;
    logic [DEF_SYMBOL_W-1:0] symbol;
  } evt_t;
endpackage

// File: rtl/ltl_evt_fifo.sv
// ltl_evt_fifo: synchronous event queue, head read straight from storage registers
module ltl_evt_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop & !empty;
  // a full queue still accepts a push when the head leaves in the same cycle
  assign do_push = push & (!full | do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/ltl_monitor_cluster.sv
// ltl_monitor_cluster: per-property fire flags, counters and a timestamped event queue
module ltl_monitor_cluster import ltl_mon_pkg::*; #(
  parameter int NUM_PROPS = DEF_NUM_PROPS,
  parameter int NUM_REPORTS = DEF_NUM_REPORTS,
  parameter int SYMBOL_W = DEF_SYMBOL_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int CYC_W = DEF_CYC_W,
  parameter int EVT_DEPTH = DEF_EVT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic [SYMBOL_W-1:0]          symbols,
  input  logic [NUM_PROPS*NUM_REPORTS-1:0] report_states,
  input  logic [NUM_PROPS-1:0]         prop_enable,
  input  logic                         clear,
  output logic [NUM_PROPS-1:0]         ltl,
  output logic [NUM_PROPS-1:0]         ltl_sticky,
  output logic [NUM_PROPS*CNT_W-1:0]   viol_count,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [NUM_PROPS-1:0]         evt_mask,
  output logic [CYC_W-1:0]             evt_cycle,
  output logic [SYMBOL_W-1:0]          evt_symbol,
  output logic                         evt_overflow
);
  localparam int EW = NUM_PROPS + CYC_W + SYMBOL_W;
  logic [NUM_PROPS-1:0] fire;
  logic [CYC_W-1:0] cyc;
  logic [EW-1:0] dout;
  logic full, empty, pop, drop;
  for (genvar p = 0; p < NUM_PROPS; p++) begin : g_fire
    assign fire[p] = run & prop_enable[p] & |report_states[p*NUM_REPORTS +: NUM_REPORTS];
  end
  assign pop = evt_valid & evt_ready;
  assign drop = |fire & full & !pop;
  assign evt_valid = !empty;
  assign {evt_mask, evt_cycle, evt_symbol} = dout;
  ltl_evt_fifo #(.W(EW), .DEPTH(EVT_DEPTH)) u_fifo (
    .clk,
    .rst(reset),
    .push(|fire),
    .din({fire, cyc, symbols}),
    .pop,
    .dout,
    .full,
    .empty
  );
  // same-cycle fires take priority over clear for sticky, counter and overflow state
  always_ff @(posedge clk)
    if (reset) begin
      ltl <= '0;
      ltl_sticky <= '0;
      viol_count <= '0;
      cyc <= '0;
      evt_overflow <= 1'b0;
    end else begin
      ltl <= fire;
      ltl_sticky <= (clear ? '0 : ltl_sticky) | fire;
      cyc <= run ? cyc + CYC_W'(1) : cyc;
      evt_overflow <= (evt_overflow & !clear) | drop;
      for (int k = 0; k < NUM_PROPS; k++)
        viol_count[k*CNT_W +: CNT_W] <= clear ? CNT_W'(fire[k]) :
          viol_count[k*CNT_W +: CNT_W] + CNT_W'(fire[k] && viol_count[k*CNT_W +: CNT_W] != '1);
    end
endmodule

// File: tb/tb_ltl_monitor_cluster.sv
// tb_ltl_monitor_cluster: directed vector table plus multi-cycle sequences
module tb_ltl_monitor_cluster;
  import ltl_mon_pkg::*;
  logic clk = 1'b0;
  logic reset, run, clear, evt_ready;
  logic [7:0] symbols;
  logic [35:0] report_states;
  logic [8:0] prop_enable;
  logic [8:0] ltl, ltl_sticky, evt_mask;
  logic [143:0] viol_count;
  logic evt_valid, evt_overflow;
  logic [31:0] evt_cycle;
  logic [7:0] evt_symbol;
  logic [8:0] s_ltl, s_sticky, s_mask;
  logic [35:0] s_count;
  logic s_valid, s_overflow;
  logic [31:0] s_cycle;
  logic [7:0] s_symbol;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic run;
    logic clr;
    logic [8:0] en;
    logic [35:0] rep;
    logic [8:0] e_ltl;
    logic [8:0] e_sticky;
  } vec_t;
  vec_t tbl[8];
  evt_t ev;

  ltl_monitor_cluster dut (
    .clk, .reset, .run, .symbols, .report_states, .prop_enable, .clear,
    .ltl, .ltl_sticky, .viol_count, .evt_valid, .evt_ready, .evt_mask,
    .evt_cycle, .evt_symbol, .evt_overflow
  );

  ltl_monitor_cluster #(.CNT_W(4)) dut_sat (
    .clk, .reset, .run, .symbols, .report_states, .prop_enable, .clear,
    .ltl(s_ltl), .ltl_sticky(s_sticky), .viol_count(s_count), .evt_valid(s_valid),
    .evt_ready, .evt_mask(s_mask), .evt_cycle(s_cycle), .evt_symbol(s_symbol),
    .evt_overflow(s_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] rb(input int p, input int r);
    rb = '0;
    rb[p*4+r] = 1'b1;
  endfunction

  function automatic logic [63:0] vc(input int p);
    return 64'(viol_count[p*16 +: 16]);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    clear = 1'b0;
    report_states = '0;
    prop_enable = '1;
    evt_ready = 1'b0;
    symbols = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 9'h1FF, rb(0,0),            9'h001, 9'h001};
    tbl[1] = '{1'b0, 1'b0, 9'h1FF, rb(1,1),            9'h000, 9'h001};
    tbl[2] = '{1'b1, 1'b0, 9'h1FF, rb(1,3) | rb(8,0),  9'h102, 9'h103};
    tbl[3] = '{1'b1, 1'b0, 9'h1FD, rb(1,2) | rb(5,1),  9'h020, 9'h123};
    tbl[4] = '{1'b1, 1'b1, 9'h1FF, 36'h0,              9'h000, 9'h000};
    tbl[5] = '{1'b1, 1'b1, 9'h1FF, rb(7,3),            9'h080, 9'h080};
    tbl[6] = '{1'b1, 1'b0, 9'h1FF, '1,                 9'h1FF, 9'h1FF};
    tbl[7] = '{1'b1, 1'b0, 9'h000, '1,                 9'h000, 9'h1FF};
    do_reset();
    chk("rst_ltl", ltl, 0);
    chk("rst_sticky", ltl_sticky, 0);
    chk("rst_count", |viol_count, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_overflow", evt_overflow, 0);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run = tbl[i].run;
      clear = tbl[i].clr;
      prop_enable = tbl[i].en;
      report_states = tbl[i].rep;
      tick();
      chk($sformatf("vec%0d_ltl", i), ltl, tbl[i].e_ltl);
      chk($sformatf("vec%0d_sticky", i), ltl_sticky, tbl[i].e_sticky);
      chk($sformatf("vec%0d_valid", i), evt_valid, |tbl[i].e_ltl);
      if (evt_valid) chk($sformatf("vec%0d_mask", i), evt_mask, tbl[i].e_ltl);
    end
    // single fire of prop 3 at cycle count 5
    do_reset();
    run = 1'b1;
    repeat (5) tick();
    symbols = 8'hA5;
    report_states = rb(3,2);
    tick();
    ev = '{mask: 9'h008, cycle: 32'd5, symbol: 8'hA5};
    chk("p3_ltl", ltl, 9'h008);
    chk("p3_sticky", ltl_sticky, 9'h008);
    chk("p3_count", vc(3), 1);
    chk("p3_valid", evt_valid, 1);
    chk("p3_event", {evt_mask, evt_cycle, evt_symbol}, ev);
    report_states = '0;
    symbols = 8'h11;
    tick();
    chk("p3_ltl_pulse", ltl, 0);
    chk("p3_sticky_hold", ltl_sticky, 9'h008);
    chk("p3_stall_payload", {evt_mask, evt_cycle, evt_symbol}, ev);
    evt_ready = 1'b1;
    tick();
    chk("p3_drained", evt_valid, 0);
    // disabled prop in the same cycle as an enabled one
    do_reset();
    run = 1'b1;
    prop_enable = 9'h1EF;
    report_states = rb(1,0) | rb(4,1);
    tick();
    chk("dis_ltl", ltl, 9'h002);
    chk("dis_mask", evt_mask, 9'h002);
    chk("dis_sticky", ltl_sticky, 9'h002);
    chk("dis_count4", vc(4), 0);
    chk("dis_count1", vc(1), 1);
    // clear with a same-cycle fire of prop 2
    prop_enable = '1;
    report_states = rb(0,1) | rb(2,0) | rb(5,3);
    tick();
    clear = 1'b1;
    report_states = rb(2,3);
    tick();
    clear = 1'b0;
    report_states = '0;
    chk("clr_sticky", ltl_sticky, 9'h004);
    chk("clr_count2", vc(2), 1);
    chk("clr_count0", vc(0), 0);
    chk("clr_count1", vc(1), 0);
    chk("clr_count5", vc(5), 0);
    // saturation of a 4-bit counter
    clear = 1'b1;
    tick();
    clear = 1'b0;
    report_states = rb(0,0);
    repeat (15) tick();
    chk("sat_at15", s_count[3:0], 15);
    repeat (5) tick();
    chk("sat_hold", s_count[3:0], 15);
    chk("sat_wide20", vc(0), 20);
    chk("sat_ltl", s_ltl[0], 1);
    report_states = '0;
    // overflow on ten fires into an eight-deep queue, then ordered drain
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      symbols = 8'(i + 16);
      report_states = rb(0,0);
      tick();
    end
    report_states = '0;
    run = 1'b0;
    chk("ovf_set", evt_overflow, 1);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), evt_valid, 1);
      chk($sformatf("drain%0d_symbol", i), evt_symbol, 64'(i + 16));
      chk($sformatf("drain%0d_cycle", i), evt_cycle, 64'(i));
      tick();
    end
    chk("drain_empty", evt_valid, 0);
    chk("ovf_sticky", evt_overflow, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovf_cleared", evt_overflow, 0);
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      report_states = rb(i,1);
      tick();
      chk($sformatf("flow%0d_mask", i), evt_mask, 64'(1) << i);
    end
    report_states = '0;
    chk("flow_no_drop", evt_overflow, 0);
    // push and pop together while full
    tick();
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      symbols = 8'(8'h40 + i);
      report_states = rb(0,0);
      tick();
    end
    chk("full_no_drop", evt_overflow, 0);
    evt_ready = 1'b1;
    symbols = 8'h48;
    tick();
    report_states = '0;
    run = 1'b0;
    chk("fullpp_no_drop", evt_overflow, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fullpp%0d_symbol", i), evt_symbol, 64'(8'h41 + i));
      tick();
    end
    chk("fullpp_empty", evt_valid, 0);
    // drop wins over clear
    evt_ready = 1'b0;
    run = 1'b1;
    report_states = rb(2,2);
    repeat (8) tick();
    clear = 1'b1;
    tick();
    chk("drop_beats_clear", evt_overflow, 1);
    report_states = '0;
    tick();
    clear = 1'b0;
    chk("clear_ovf", evt_overflow, 0);
    // reset with queued events and a same-cycle fire/clear
    do_reset();
    run = 1'b1;
    report_states = rb(6,0);
    repeat (3) tick();
    chk("pre_rst_valid", evt_valid, 1);
    reset = 1'b1;
    clear = 1'b1;
    report_states = rb(6,1);
    tick();
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_ltl", ltl, 0);
    chk("mid_rst_sticky", ltl_sticky, 0);
    chk("mid_rst_count", |viol_count, 0);
    chk("mid_rst_ovf", evt_overflow, 0);
    reset = 1'b0;
    clear = 1'b0;
    report_states = rb(6,0);
    tick();
    chk("post_rst_valid", evt_valid, 1);
    chk("post_rst_cycle", evt_cycle, 0);
    chk("post_rst_mask", evt_mask, 9'h040);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
